hiscore_upload: RTL
===================

# hiscore_upload

Responder for HPS-initiated ioctl uploads (core → HPS readback), the opposite direction of the ROM/DIP download path. When the HPS opens an upload on the configured index, the block pauses the game CPU via a req/ack handshake. It then serves each ioctl read strobe with a byte fetched from the core's high-score/NVRAM shadow RAM, holding ioctl_wait until the byte is valid. It sits in the top level between hps_io and the core's dual-port work-RAM mirror.

## Interface
- INDEX, 8'd4: ioctl_index value that selects this block.
- ADDR_W, 10: RAM byte-address width; valid upload addresses are 0 .. 2^ADDR_W-1.
- RAM_LAT, 2: RAM read latency in clocks, 1..7.

Ports:
- clk_sys, in, 1: system clock (36.864 MHz domain).
- reset_n, in, 1: reset, asynchronous, active-low.
- ioctl_upload, in, 1: upload session active (level).
- ioctl_index, in, 8: session index.
- ioctl_rd, in, 1: one-cycle read strobe; ioctl_addr is valid in the same cycle.
- ioctl_addr, in, 25: byte address.
- ioctl_din, out, 8: read data to hps_io.
- ioctl_wait, out, 1: HPS must not issue ioctl_rd while this is high.
- pause_req, out, 1: request that the core halt its CPU.
- pause_ack, in, 1: core is halted; RAM contents are stable.
- ram_addr, out, ADDR_W: RAM read address.
- ram_rd, out, 1: one-cycle RAM read enable.
- ram_q, in, 8: RAM read data.
- busy, out, 1: session active, i.e. state is not IDLE.
- rd_drop, out, 1: sticky flag; an ioctl_rd arrived while ioctl_wait was high.

## Operation
- Session start: `sel = ioctl_upload & (ioctl_index == INDEX)`. A session starts on the rising edge of sel.
- State machine:
  - IDLE → PAUSE on the rising edge of sel. In PAUSE, pause_req=1 and ioctl_wait=1.
  - PAUSE → READY when pause_ack=1. In READY, ioctl_wait=0.
  - READY with ioctl_rd and `ioctl_addr < 2^ADDR_W`: latch `ioctl_addr[ADDR_W-1:0]` into ram_addr, set ioctl_wait=1, go to FETCH.
  - FETCH: ram_rd=1 for exactly one cycle, then go to LATW.
  - LATW: wait until ram_q is valid, capture ram_q into ioctl_din, clear ioctl_wait, return to READY.
  - READY with ioctl_rd and ioctl_addr out of range: ioctl_din <= 8'hFF and ioctl_wait pulses for 1 cycle. No RAM access occurs and the state returns to READY.
  - READY with pause_ack=0: go back to PAUSE (ioctl_wait=1) until ack returns.
  - Any state with sel=0 → IDLE. This drops pause_req and clears ioctl_wait. An in-flight fetch is abandoned, and ioctl_din keeps its last value.
- ioctl_rd while ioctl_wait=1, or while in PAUSE: the strobe is ignored and rd_drop is set. rd_drop clears only on reset or at the start of a new session.
- Index mismatch: the block stays in IDLE and all outputs hold their reset values, except that ioctl_din holds its last value.
- Address width rule: only `ioctl_addr[24:ADDR_W] == 0` counts as in range. Addresses never wrap.
- Reset values (reset_n=0, async): state=IDLE, ioctl_din=8'h00, ioctl_wait=0, pause_req=0, ram_addr=0, ram_rd=0, busy=0, rd_drop=0.

## Timing
- All outputs are registered.
- Session start: sel is seen high at edge E, and pause_req=1 and ioctl_wait=1 from edge E.
- PAUSE exit: pause_ack is sampled at edge A, and ioctl_wait=0 after edge A.
- Read sequence, with ioctl_rd sampled at edge N:
  - ioctl_wait=1, ram_addr and ram_rd=1 after edge N.
  - ram_rd drops after edge N+1.
  - ram_q is sampled at edge N+1+RAM_LAT.
  - ioctl_din is updated and ioctl_wait=0 after that same edge.
  - ioctl_wait is therefore high for exactly RAM_LAT+1 cycles.
- Out-of-range read: ioctl_din=8'hFF and ioctl_wait=1 after edge N; ioctl_wait=0 after edge N+1.
- Simultaneous events:
  - sel falling with ioctl_rd in the same cycle: the session end wins and no fetch is issued.
  - pause_ack falling in the same cycle as ioctl_rd in READY: the read is accepted and completes, then the state moves to PAUSE.
- Back-to-back reads: the earliest accepted next strobe is the first edge at which ioctl_wait=0 is sampled.

## Test plan
- Session with RAM_LAT=2: upload=1, index=4, ack arrives after 5 cycles. Check pause_req high from the first edge, ioctl_wait high for 5 cycles and then 0, busy=1.
- Read sequence: RAM[0x123]=0xA5, rd at addr 0x123. Check ram_addr=0x123, ram_rd high for 1 cycle, ioctl_wait high for 3 cycles, ioctl_din=0xA5.
- Out of range: rd at addr 0x400 with ADDR_W=10. Check ioctl_din=0xFF, ioctl_wait high for 1 cycle, ram_rd never asserted.
- Protocol violations: rd issued during ioctl_wait → rd_drop=1, din unchanged. Then rd with index=5 → no pause_req and no outputs change.
- Aborts: drop upload mid-LATW → state IDLE next edge, pause_req=0, ioctl_wait=0, din keeps its old value. Drop pause_ack in READY → ioctl_wait=1 until ack returns.
- Reset: assert reset_n=0 asynchronously mid-fetch. All outputs reach reset values without a clock edge, and the session restarts only on a new rising edge of sel.

Source files
------------

// File: rtl/hiscore_upload_if.sv
// hiscore_upload_if: groups the hps_io ioctl upload signals, the CPU pause
// handshake and the work-RAM read port used by the hiscore_upload responder.
interface hiscore_upload_if #(
  parameter int ADDR_W = 10
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              pause_req;
  logic              pause_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              busy;
  logic              rd_drop;

  // Environment side: hps_io, the core CPU and the RAM mirror.
  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, pause_ack, ram_q,
    input  ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy, rd_drop
  );

  // Responder side: the hiscore_upload block itself.
  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, pause_ack, ram_q,
    output ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy, rd_drop
  );
endinterface

// File: rtl/hiscore_upload.sv
// hiscore_upload: answers HPS ioctl upload reads with bytes from the core's
// high-score shadow RAM, holding the game CPU paused for the whole session.
// Every output is a flop; the output comb process only computes next values.
module hiscore_upload #(
  parameter logic [7:0] INDEX   = 8'd4,
  parameter int         ADDR_W  = 10,
  parameter int         RAM_LAT = 2
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  hiscore_upload_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PAUSE, READY, FETCH, LATW} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              sel;
  logic              sel_d;
  logic              sel_rise;
  logic              in_range;
  logic              accept;
  logic              fetch_go;
  logic              oor_go;
  logic              capture;
  logic              lat_done;
  logic [2:0]        lat_cnt;
  logic [7:0]        din_nxt;
  logic              wait_nxt;
  logic              pause_req_nxt;
  logic              ram_rd_nxt;
  logic              busy_nxt;
  logic              rd_drop_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;

  assign sel      = bus.ioctl_upload & (bus.ioctl_index == INDEX);
  assign sel_rise = sel & ~sel_d;
  assign in_range = (bus.ioctl_addr[24:ADDR_W] == '0);
  assign lat_done = (lat_cnt == 3'd0);
  assign accept   = sel && (state == READY) && bus.ioctl_rd && !bus.ioctl_wait;
  assign fetch_go = accept & in_range;
  assign oor_go   = accept & ~in_range;
  assign capture  = sel && (state == LATW) && lat_done;

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; losing sel ends the session from any state.
  always_comb begin
    state_nxt = state;
    if (!sel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (sel_rise) state_nxt = PAUSE;
        PAUSE:   if (bus.pause_ack) state_nxt = READY;
        READY: begin
          if (fetch_go)                          state_nxt = FETCH;
          else if (!accept && !bus.pause_ack)    state_nxt = PAUSE;
        end
        FETCH:   state_nxt = LATW;
        LATW:    if (lat_done) state_nxt = READY;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values for the registered outputs, decoded from the upcoming state.
  always_comb begin
    pause_req_nxt = (state_nxt != IDLE);
    busy_nxt      = (state_nxt != IDLE);
    ram_rd_nxt    = (state_nxt == FETCH);
    case (state_nxt)
      PAUSE, FETCH, LATW: wait_nxt = 1'b1;
      READY:              wait_nxt = oor_go;
      default:            wait_nxt = 1'b0;
    endcase
    ram_addr_nxt = fetch_go ? bus.ioctl_addr[ADDR_W-1:0] : bus.ram_addr;
    din_nxt = bus.ioctl_din;
    if (oor_go)       din_nxt = 8'hFF;
    else if (capture) din_nxt = bus.ram_q;
    rd_drop_nxt = bus.rd_drop;
    if (sel_rise)
      rd_drop_nxt = 1'b0;
    else if (sel && (state != IDLE) && bus.ioctl_rd &&
             (bus.ioctl_wait || (state == PAUSE)))
      rd_drop_nxt = 1'b1;
  end

  // Output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.ioctl_din  <= 8'h00;
      bus.ioctl_wait <= 1'b0;
      bus.pause_req  <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_rd     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.rd_drop    <= 1'b0;
    end else begin
      bus.ioctl_din  <= din_nxt;
      bus.ioctl_wait <= wait_nxt;
      bus.pause_req  <= pause_req_nxt;
      bus.ram_addr   <= ram_addr_nxt;
      bus.ram_rd     <= ram_rd_nxt;
      bus.busy       <= busy_nxt;
      bus.rd_drop    <= rd_drop_nxt;
    end
  end

  // sel history resets high so a session still selected across a reset does
  // not restart until sel drops and rises again; lat_cnt times the RAM latency.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel_d   <= 1'b1;
      lat_cnt <= 3'd0;
    end else begin
      sel_d <= sel;
      if (state == FETCH)
        lat_cnt <= 3'(RAM_LAT - 1);
      else if ((state == LATW) && !lat_done)
        lat_cnt <= lat_cnt - 3'd1;
    end
  end

endmodule
